e_mdu: RTL and testbench

Execute-stage multiply/divide unit for the pipelined MIPS core, sitting beside the ALU and sharing its operands. It owns the HI/LO registers and executes mult/multu/div/divu with fixed multi-cycle latency. It also executes mthi/mtlo writes and mfhi/mflo reads, and drives a busy flag consumed by the D-stage stall logic. mdu_out is muxed with the ALU result into the E/M pipeline register.

---
 rtl/e_mdu.sv | 190 +++++++++++++++++++
 tb/tb_e_mdu.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs mult/multu/div/divu with fixed latency.
// Optional madd/maddu/msub/msubu accumulate ops are built when E_MDU_MADD_EN is defined.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  mdu_sel,
  input  logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_out
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef E_MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  function automatic logic [63:0] mul_s(input logic signed [31:0] x, input logic signed [31:0] y);
    logic signed [63:0] xe;
    logic signed [63:0] ye;
    logic signed [63:0] p;
    xe = {{32{x[31]}}, x};
    ye = {{32{y[31]}}, y};
    p  = xe * ye;
    return p;
  endfunction

  function automatic logic [63:0] mul_u(input logic [31:0] x, input logic [31:0] y);
    return {32'b0, x} * {32'b0, y};
  endfunction

  // Returns {remainder, quotient}; the most-negative / -1 overflow is pinned to a defined value.
  function automatic logic [63:0] div_s(input logic signed [31:0] x, input logic signed [31:0] y);
    logic signed [31:0] q;
    logic signed [31:0] r;
    if (y == 32'sd0) begin
      q = '0;
      r = '0;
    end else if (x == 32'sh80000000 && y == -32'sd1) begin
      q = x;
      r = '0;
    end else begin
      q = x / y;
      r = x % y;
    end
    return {r, q};
  endfunction

  function automatic logic [63:0] div_u(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] q;
    logic [31:0] r;
    if (y == 32'd0) begin
      q = '0;
      r = '0;
    end else begin
      q = x / y;
      r = x % y;
    end
    return {r, q};
  endfunction

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      a_q, b_q;
  logic [3:0]       op_q;
  logic             ld;
  logic             is_mc;
  logic             is_div;
  logic [63:0]      res;
  logic             res_wr;

  always_comb begin
    is_div = (mdu_sel == OP_DIV) || (mdu_sel == OP_DIVU);
    is_mc  = (mdu_sel == OP_MULT) || (mdu_sel == OP_MULTU) || is_div;
`ifdef E_MDU_MADD_EN
    if (mdu_sel == OP_MADD || mdu_sel == OP_MADDU ||
        mdu_sel == OP_MSUB || mdu_sel == OP_MSUBU)
      is_mc = 1'b1;
`endif
  end

  // Completion result from the latched operands; accumulate ops read HI/LO as they stand now.
  always_comb begin
    res    = {hi_q, lo_q};
    res_wr = 1'b1;
    case (op_q)
      OP_MULT:  res = mul_s(a_q, b_q);
      OP_MULTU: res = mul_u(a_q, b_q);
      OP_DIV: begin
        if (b_q == 32'd0) res_wr = 1'b0;
        else              res = div_s(a_q, b_q);
      end
      OP_DIVU: begin
        if (b_q == 32'd0) res_wr = 1'b0;
        else              res = div_u(a_q, b_q);
      end
`ifdef E_MDU_MADD_EN
      OP_MADD:  res = {hi_q, lo_q} + mul_s(a_q, b_q);
      OP_MADDU: res = {hi_q, lo_q} + mul_u(a_q, b_q);
      OP_MSUB:  res = {hi_q, lo_q} - mul_s(a_q, b_q);
      OP_MSUBU: res = {hi_q, lo_q} - mul_u(a_q, b_q);
`endif
      default:  res_wr = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    ld      = 1'b0;
    if (state_q == S_IDLE) begin
      if (start && is_mc) begin
        state_d = S_RUN;
        cnt_d   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        ld      = 1'b1;
      end else if (!start) begin
        if (mdu_sel == OP_MTHI) hi_d = a;
        if (mdu_sel == OP_MTLO) lo_d = a;
      end
    end else begin
      if (cnt_q == CNT_W'(1)) begin
        state_d = S_IDLE;
        cnt_d   = '0;
        if (res_wr) {hi_d, lo_d} = res;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Operand/op latch is pure data and needs no reset.
  always_ff @(posedge clk) begin
    if (ld) begin
      a_q  <= a;
      b_q  <= b;
      op_q <= mdu_sel;
    end
  end

  always_comb begin
    mdu_out = '0;
    if (mdu_sel == OP_MFHI) mdu_out = hi_q;
    if (mdu_sel == OP_MFLO) mdu_out = lo_q;
  end

  assign busy = (state_q == S_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: scoreboard of expected {hi,lo} popped when busy falls.
module tb_e_mdu;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic [3:0]  mdu_sel;
  logic        start;
  logic        busy;
  logic [31:0] hi, lo, mdu_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] sb_q[$];
  logic [63:0] exp_hl;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .mdu_sel(mdu_sel), .start(start),
    .busy(busy), .hi(hi), .lo(lo), .mdu_out(mdu_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input int pre, input int n, input string tag);
    int cnt;
    logic [63:0] e;
    cnt = pre;
    while (busy && cnt < 60) begin
      cnt++;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, 64'(cnt), 64'(n));
    if (sb_q.size() == 0) begin
      check({tag, " sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check({tag, " hilo"}, {hi, lo}, e);
      exp_hl = e;
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                       input logic [63:0] exp, input int n, input string tag);
    mdu_sel = op; a = av; b = bv; start = 1'b1;
    sb_q.push_back(exp);
    @(negedge clk);
    start = 1'b0; mdu_sel = 4'd0; a = $urandom; b = $urandom;
    wait_done(0, n, tag);
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] v);
    mdu_sel = op; a = v; start = 1'b0;
    @(negedge clk);
    mdu_sel = 4'd0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] av, bv;
    longint sp;
    int q, r;
    reset = 1'b1; start = 1'b0; mdu_sel = 4'd0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst hi", 64'(hi), 64'd0);
    check("rst lo", 64'(lo), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst mdu_out", 64'(mdu_out), 64'd0);
    reset = 1'b0;
    exp_hl = '0;
    @(negedge clk);

    issue(4'd1, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 5, "mult");
    mdu_sel = 4'd7; #1 check("mfhi", 64'(mdu_out), 64'hFFFFFFFF);
    mdu_sel = 4'd8; #1 check("mflo", 64'(mdu_out), 64'hFFFFFFF1);
    mdu_sel = 4'd13; #1 check("illegal mdu_out", 64'(mdu_out), 64'd0);
    mdu_sel = 4'd0;
    @(negedge clk);

    issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 5, "multu");
    issue(4'd4, 32'd7, 32'd2, 64'h00000001_00000003, 10, "divu");
    issue(4'd3, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 10, "div");

    mt(4'd5, 32'h11);
    mt(4'd6, 32'h22);
    check("mthi/mtlo", {hi, lo}, 64'h00000011_00000022);
    exp_hl = 64'h00000011_00000022;
    issue(4'd3, 32'd5, 32'd0, exp_hl, 10, "div0");

    issue(4'd13, 32'd9, 32'd9, exp_hl, 0, "illegal start");

    // Second start and an mthi during RUN must both be ignored.
    mdu_sel = 4'd1; a = 32'd3; b = 32'd4; start = 1'b1;
    sb_q.push_back(64'd12);
    @(negedge clk);
    start = 1'b0; mdu_sel = 4'd0;
    @(negedge clk);
    start = 1'b1; mdu_sel = 4'd1; a = 32'd100; b = 32'd100;
    @(negedge clk);
    start = 1'b0; mdu_sel = 4'd5; a = 32'hDEAD;
    @(negedge clk);
    mdu_sel = 4'd0;
    wait_done(3, 5, "start_while_busy");
    @(negedge clk);
    check("no second op busy", 64'(busy), 64'd0);
    check("no second op hilo", {hi, lo}, 64'd12);

    // Reset during RUN aborts and clears HI/LO.
    mdu_sel = 4'd3; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mdu_sel = 4'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort hilo", {hi, lo}, 64'd0);
    repeat (12) @(negedge clk);
    check("no late write", {hi, lo}, 64'd0);

    reset = 1'b1; start = 1'b1; mdu_sel = 4'd1; a = 32'd2; b = 32'd3;
    @(negedge clk);
    reset = 1'b0; start = 1'b0; mdu_sel = 4'd0;
    check("reset over start busy", 64'(busy), 64'd0);
    repeat (6) @(negedge clk);
    check("reset over start hilo", {hi, lo}, 64'd0);
    exp_hl = '0;

    mt(4'd5, 32'h0);
    mt(4'd6, 32'hFFFFFFFF);
`ifdef E_MDU_MADD_EN
    issue(4'd10, 32'd1, 32'd1, 64'h00000001_00000000, 5, "maddu");
`else
    issue(4'd10, 32'd1, 32'd1, 64'h00000000_FFFFFFFF, 0, "maddu_off");
`endif

    for (int i = 0; i < 4; i++) begin
      av = $urandom; bv = $urandom;
      sp = longint'(int'(av)) * longint'(int'(bv));
      issue(4'd1, av, bv, 64'(sp), 5, "rand mult");
      av = $urandom; bv = $urandom;
      issue(4'd2, av, bv, 64'(av) * 64'(bv), 5, "rand multu");
      av = $urandom; bv = $urandom;
      if (bv == 32'd0 || bv == 32'hFFFFFFFF) bv = 32'd3;
      q = int'(av) / int'(bv);
      r = int'(av) % int'(bv);
      issue(4'd3, av, bv, {r, q}, 10, "rand div");
      av = $urandom; bv = $urandom_range(1, 32'h0FFFFFFF);
      issue(4'd4, av, bv, {av % bv, av / bv}, 10, "rand divu");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
